// File: rtl/front_panel_pkg.sv
// Shared constants for the front-panel controller:
// switch codes, LED bank layout and default sizes.
package front_panel_pkg;

  localparam logic [1:0] SW_CENTRE = 2'b00;
  localparam logic [1:0] SW_UP     = 2'b01;
  localparam logic [1:0] SW_DOWN   = 2'b10;

  localparam int LED_STATUS_LO = 0;
  localparam int LED_STATUS_HI = 9;
  localparam int LED_DATA_LO   = 10;
  localparam int LED_DATA_HI   = 17;
  localparam int LED_WAIT      = 18;
  localparam int LED_HLDA      = 19;
  localparam int LED_ADDR_LO   = 20;
  localparam int LED_ADDR_HI   = 35;

  localparam int DEF_NUM_SW  = 25;
  localparam int DEF_NUM_LED = 36;

endpackage

// File: rtl/front_panel_if.sv
// One panel switch: raw pin code in,
// debounced code and action pulses out.
interface front_panel_if;
  logic [1:0] raw;
  logic [1:0] stable;
  logic       up;
  logic       down;

  modport master (
    output raw,
    input  stable, up, down
  );

  modport slave (
    input  raw,
    output stable, up, down
  );
endinterface

// File: rtl/panel_switch_debounce.sv
// Synchroniser, debounce counter and up/down
// action pulses for a single two-bit switch.
module panel_switch_debounce
  import front_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset_n,
  front_panel_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync1, sync2;
  logic [1:0]    s;
  logic [1:0]    cand, stable;
  logic [CW-1:0] cnt;
  logic          up, down;

  // an illegal 11 is folded to centre right after the synchroniser
  assign s = (sync2 == 2'b11) ? SW_CENTRE : sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= SW_CENTRE;
      stable <= SW_CENTRE;
      cnt    <= '0;
      up     <= 1'b0;
      down   <= 1'b0;
    end else begin
      sync1 <= bus.raw;
      sync2 <= sync1;
      up    <= 1'b0;
      down  <= 1'b0;
      if (s != cand) begin
        cand <= s;
        cnt  <= '0;
      end else if (cand == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= cand;
        cnt    <= '0;
        up     <= (cand == SW_UP);
        down   <= (cand == SW_DOWN);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.stable = stable;
  assign bus.up     = up;
  assign bus.down   = down;

endmodule

// File: rtl/front_panel_controller.sv
// Panel switch debouncing plus registered LED bank
// with switch mirroring, per-LED blink and lamp test.
module front_panel_controller
  import front_panel_pkg::*;
#(
  parameter int NUM_SW          = DEF_NUM_SW,
  parameter int NUM_LED         = DEF_NUM_LED,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLINK_DIV       = 12500000,
  parameter int MIRROR_BASE     = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2*NUM_SW-1:0] sw_raw,
  output logic [2*NUM_SW-1:0] sw_stable,
  output logic [NUM_SW-1:0]   sw_up_pulse,
  output logic [NUM_SW-1:0]   sw_down_pulse,
  input  logic [NUM_LED-1:0]  led_src,
  input  logic [NUM_LED-1:0]  led_blink_en,
  input  logic                mirror_mode,
  input  logic                lamp_test,
  output logic [NUM_LED-1:0]  leds
);

  localparam int BW = $clog2(BLINK_DIV);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    front_panel_if bus ();
    assign bus.raw = sw_raw[2*i +: 2];
    panel_switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );
    assign sw_stable[2*i +: 2] = bus.stable;
    assign sw_up_pulse[i]      = bus.up;
    assign sw_down_pulse[i]    = bus.down;
  end

  logic [BW-1:0] blink_cnt;
  logic          phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  logic [NUM_LED-1:0] mir, mir_en;

  // only LEDs that land on a real switch are mirrored
  for (genvar j = 0; j < NUM_LED; j++) begin : g_mir
    if (j >= MIRROR_BASE && j < MIRROR_BASE + NUM_SW) begin : g_on
      assign mir[j]    = |sw_stable[2*(j-MIRROR_BASE) +: 2];
      assign mir_en[j] = 1'b1;
    end else begin : g_off
      assign mir[j]    = 1'b0;
      assign mir_en[j] = 1'b0;
    end
  end

  logic [NUM_LED-1:0] base, v;

  always_comb begin
    base = led_src;
    v    = '1;
    if (mirror_mode)
      base = (mir_en & mir) | (~mir_en & led_src);
    if (!lamp_test)
      v = base & (~led_blink_en | {NUM_LED{phase}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) leds <= '0;
    else          leds <= v;
  end

endmodule

// File: tb/tb_front_panel_controller.sv
// Directed self-checking bench for front_panel_controller
// with short debounce and blink periods.
module tb_front_panel_controller;

  localparam int NSW  = 25;
  localparam int NLED = 36;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2*NSW-1:0] sw_raw;
  logic [2*NSW-1:0] sw_stable;
  logic [NSW-1:0]  sw_up_pulse;
  logic [NSW-1:0]  sw_down_pulse;
  logic [NLED-1:0] led_src;
  logic [NLED-1:0] led_blink_en;
  logic            mirror_mode;
  logic            lamp_test;
  logic [NLED-1:0] leds;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  front_panel_controller #(
    .NUM_SW(NSW), .NUM_LED(NLED), .DEBOUNCE_CYCLES(4),
    .BLINK_DIV(4), .MIRROR_BASE(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
    .sw_stable(sw_stable), .sw_up_pulse(sw_up_pulse),
    .sw_down_pulse(sw_down_pulse), .led_src(led_src),
    .led_blink_en(led_blink_en), .mirror_mode(mirror_mode),
    .lamp_test(lamp_test), .leds(leds)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    sw_raw = '0; led_src = '0; led_blink_en = '0;
    mirror_mode = 1'b0; lamp_test = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (sw_stable !== '0) begin
      n_fail++; $display("FAIL reset_stable got %h want 0", sw_stable);
    end
    n_checks++;
    if (sw_up_pulse !== '0 || sw_down_pulse !== '0) begin
      n_fail++; $display("FAIL reset_pulses got %h/%h want 0", sw_up_pulse, sw_down_pulse);
    end
    n_checks++;
    if (leds !== '0) begin
      n_fail++; $display("FAIL reset_leds got %h want 0", leds);
    end
    repeat (3) @(posedge clk);
    #4 reset_n = 1'b1;
    tick();
    n_checks++;
    if (leds !== '0) begin
      n_fail++; $display("FAIL post_reset_leds got %h want 0", leds);
    end
  endtask

  task automatic test_latency();
    logic [NSW-1:0]   eu;
    logic [2*NSW-1:0] es;
    sw_raw = 50'h40;
    for (int n = 1; n <= 9; n++) begin
      tick();
      eu = (n == 7) ? 25'h8 : 25'h0;
      es = (n >= 7) ? 50'h40 : 50'h0;
      n_checks++;
      if (sw_up_pulse !== eu || sw_down_pulse !== '0) begin
        n_fail++;
        $display("FAIL latency_pulse n=%0d got %h/%h want %h/0", n, sw_up_pulse, sw_down_pulse, eu);
      end
      n_checks++;
      if (sw_stable !== es) begin
        n_fail++; $display("FAIL latency_stable n=%0d got %h want %h", n, sw_stable, es);
      end
    end
  endtask

  task automatic test_glitch();
    sw_raw = 50'h41;
    repeat (3) tick();
    sw_raw = 50'h40;
    for (int n = 0; n < 12; n++) begin
      tick();
      n_checks++;
      if (sw_stable !== 50'h40 || sw_up_pulse !== '0 || sw_down_pulse !== '0) begin
        n_fail++;
        $display("FAIL glitch n=%0d got %h %h/%h want 40 0/0", n, sw_stable, sw_up_pulse, sw_down_pulse);
      end
    end
  endtask

  task automatic test_direct();
    int dn, oth;
    sw_raw = 50'h440;
    repeat (10) tick();
    n_checks++;
    if (sw_stable !== 50'h440) begin
      n_fail++; $display("FAIL direct_setup got %h want 440", sw_stable);
    end
    sw_raw = 50'h840;
    dn = 0; oth = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (sw_down_pulse == 25'h20) dn++;
      if (sw_up_pulse != '0 || (sw_down_pulse != '0 && sw_down_pulse != 25'h20)) oth++;
    end
    n_checks++;
    if (dn != 1 || oth != 0) begin
      n_fail++; $display("FAIL direct_pulses got dn=%0d other=%0d want 1/0", dn, oth);
    end
    n_checks++;
    if (sw_stable !== 50'h840) begin
      n_fail++; $display("FAIL direct_stable got %h want 840", sw_stable);
    end
    sw_raw = 50'h8C0;
    oth = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (sw_up_pulse != '0 || sw_down_pulse != '0) oth++;
    end
    n_checks++;
    if (oth != 0) begin
      n_fail++; $display("FAIL illegal_pulses got %0d want 0", oth);
    end
    n_checks++;
    if (sw_stable !== 50'h800) begin
      n_fail++; $display("FAIL illegal_stable got %h want 800", sw_stable);
    end
  endtask

  task automatic test_mirror();
    sw_raw = 50'h20;
    repeat (12) tick();
    n_checks++;
    if (sw_stable !== 50'h20) begin
      n_fail++; $display("FAIL mirror_setup got %h want 20", sw_stable);
    end
    mirror_mode = 1'b1; led_src = '0;
    tick();
    n_checks++;
    if (leds !== 36'h0_0040_0000) begin
      n_fail++; $display("FAIL mirror_on got %h want 000400000", leds);
    end
    led_src = 36'hA_5A5A_5A5A;
    tick();
    n_checks++;
    if (leds !== 36'h0_004A_5A5A) begin
      n_fail++; $display("FAIL mirror_mix got %h want 0004a5a5a", leds);
    end
    mirror_mode = 1'b0;
    tick();
    n_checks++;
    if (leds !== 36'hA_5A5A_5A5A) begin
      n_fail++; $display("FAIL mirror_off got %h want a5a5a5a5a", leds);
    end
    led_src = '0;
    tick();
    n_checks++;
    if (leds !== '0) begin
      n_fail++; $display("FAIL mirror_off_zero got %h want 0", leds);
    end
  endtask

  task automatic test_blink();
    logic [NLED-1:0] e;
    sw_raw = '0; led_src = 36'h1; led_blink_en = 36'h1;
    tick();
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (leds !== '0) begin
      n_fail++; $display("FAIL blink_reset got %h want 0", leds);
    end
    #1 reset_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      e = (((n - 1) / 4) % 2 == 1) ? 36'h1 : 36'h0;
      n_checks++;
      if (leds !== e) begin
        n_fail++; $display("FAIL blink n=%0d got %h want %h", n, leds, e);
      end
    end
    lamp_test = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      n_checks++;
      if (leds !== 36'hF_FFFF_FFFF) begin
        n_fail++; $display("FAIL lamp_test n=%0d got %h want all ones", n, leds);
      end
    end
    lamp_test = 1'b0; led_blink_en = '0;
  endtask

  task automatic test_async_reset();
    logic [NSW-1:0] eu;
    led_src = '1;
    repeat (2) tick();
    n_checks++;
    if (leds !== 36'hF_FFFF_FFFF) begin
      n_fail++; $display("FAIL ar_leds_before got %h want all ones", leds);
    end
    sw_raw = 50'h40;
    repeat (5) tick();
    n_checks++;
    if (sw_stable !== '0 || sw_up_pulse !== '0) begin
      n_fail++; $display("FAIL ar_midcount got %h/%h want 0/0", sw_stable, sw_up_pulse);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (leds !== '0 || sw_stable !== '0 || sw_up_pulse !== '0 || sw_down_pulse !== '0) begin
      n_fail++;
      $display("FAIL ar_immediate got %h %h %h/%h want all 0", leds, sw_stable, sw_up_pulse, sw_down_pulse);
    end
    #1 reset_n = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      eu = (n == 7) ? 25'h8 : 25'h0;
      n_checks++;
      if (sw_up_pulse !== eu || sw_stable !== ((n >= 7) ? 50'h40 : 50'h0)) begin
        n_fail++; $display("FAIL ar_relatch n=%0d got %h/%h want %h", n, sw_up_pulse, sw_stable, eu);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_direct();
    test_mirror();
    test_blink();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/front_panel_controller.md
Name: front_panel_controller

Overview:
- Parametrised successor to the front-panel switch-to-LED mapping.
- Synchronises and debounces every three-position panel switch, and produces one-cycle up/down action pulses for EXAMINE, DEPOSIT, RUN, etc.
- Drives the registered LED bank from machine status, with switch mirroring, per-LED blink and lamp test.
- Sits between the panel I/O pins and the Altair core's front-panel logic.

Parameters:
- NUM_SW, 25, number of two-bit panel switches.
- NUM_LED, 36, number of panel LEDs (0-9 status, 10-17 data, 18-19 WAIT/HLDA, 20-35 address).
- DEBOUNCE_CYCLES, 50000, stable cycles required before a switch change is accepted; minimum 2.
- BLINK_DIV, 12500000, clk cycles per blink half-period; minimum 2.
- MIRROR_BASE, 20, first LED index driven by switch 0 in mirror mode.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sw_raw  in  2*NUM_SW  raw switch codes, switch i at bits [2i+1:2i]; 00 centre, 01 up, 10 down, 11 illegal
- sw_stable  out  2*NUM_SW  debounced switch codes
- sw_up_pulse  out  NUM_SW  one-cycle pulse on an accepted transition into 01
- sw_down_pulse  out  NUM_SW  one-cycle pulse on an accepted transition into 10
- led_src  in  NUM_LED  machine status LED values from the core
- led_blink_en  in  NUM_LED  per-LED blink enable
- mirror_mode  in  1  mirror the switches onto the address LEDs
- lamp_test  in  1  force all LEDs on
- leds  out  NUM_LED  registered LED drive, active-high

Behaviour:
- Reset: asynchronous assert, released on clk. All of the following clear to 0: sync flops, candidate, counters, sw_stable, both pulse vectors, blink counter, blink phase and leds.
- Synchroniser: two flops per bit. The synchronised code 11 is treated as 00 from this point on.
- Debounce, per switch, on the synchronised code s:
  - If s != candidate: candidate <= s, cnt <= 0.
  - Else if candidate == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= candidate, cnt <= 0, and the matching pulse fires.
  - Otherwise: cnt <= cnt+1.
- Counter width is $clog2(DEBOUNCE_CYCLES); the counter never wraps.
- Latency: with raw held from the sampling edge E0, sw_stable and the pulse update at edge E0+DEBOUNCE_CYCLES+2.
- A glitch shorter than DEBOUNCE_CYCLES produces no change and no pulse.
- A mid-count change to another non-stable code restarts the count.
- Pulses:
  - up_pulse fires only when the new stable code is 01; down_pulse only when it is 10.
  - Each pulse is exactly one cycle wide.
  - A return to 00 produces no pulse. An up-to-down change without passing centre produces down_pulse only.
- Blink: a free-running counter runs 0..BLINK_DIV-1. At wrap the phase toggles; it is 0 after reset.
- LED value vector v[j], before registering:
  - If lamp_test: 1.
  - Else if mirror_mode and MIRROR_BASE <= j < MIRROR_BASE+NUM_SW and j < NUM_LED: |sw_stable of switch j-MIRROR_BASE.
  - Otherwise: led_src[j].
  - Blinking then applies only when lamp_test=0: v[j] &= ~led_blink_en[j] | phase.
- Output: leds <= v on every edge, one-cycle latency from led_src, mode inputs and sw_stable.
- Simultaneous events: all switches are independent, so pulses on several switches may fire in the same cycle. lamp_test overrides mirroring and blinking.
- Reset mid-debounce discards the pending change. After release, a still-held non-centre switch is re-accepted with full latency and produces a pulse.

Decomposition:
- Package front_panel_pkg holds:
  - switch code constants SW_CENTRE=2'b00, SW_UP=2'b01, SW_DOWN=2'b10;
  - LED index ranges: status 0-9, data 10-17, WAIT/HLDA 18-19, address 20-35;
  - default NUM_SW and NUM_LED.
- One sub-module, panel_switch_debounce: handles a single two-bit switch (synchroniser, candidate, counter, stable, pulses). It is instantiated NUM_SW times with a generate loop; the LED/blink logic stays in the top.

Test Plan:
- Reset and latency (DEBOUNCE_CYCLES=4): switch 3 raw 00->01 held -> sw_stable[7:6]=01 and sw_up_pulse[3]=1 for exactly one cycle at edge E0+6; no other pulses.
- Glitch rejection (DEBOUNCE_CYCLES=4): switch 0 at 01 for 3 cycles, then 00 -> sw_stable stays 00 and no pulse.
- Direct change and illegal code: switch 5 01->10 held -> down_pulse[5] only. Raw 11 held on a stable-01 switch -> stable 00 with no pulse.
- Mirror (defaults): mirror_mode=1, switch 2 stable 10, led_src all 0 -> leds[22]=1 one cycle later, all other LEDs 0. With mirror_mode=0 -> leds[22]=led_src[22].
- Blink/lamp test (BLINK_DIV=4): led_blink_en[0]=1, led_src[0]=1 -> leds[0] alternates 4 cycles off, 4 cycles on. lamp_test=1 -> leds all ones, including blinking LEDs.
- Async reset mid-debounce: assert reset_n=0 at count 2 -> all outputs 0 immediately. After release with raw still 01 -> up_pulse at E0+DEBOUNCE_CYCLES+2.
